uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Shares one UART transmitter (8N1, uart_en rising-edge start, tx_done one-cycle pulse at end of frame) among N_REQ byte-stream requesters.
- Round-robin arbitration at packet granularity: the grant holds until the granted requester's byte marked last has been sent.
- Sequences each byte: capture, start pulse to the transmitter, wait for tx_done, optional inter-byte gap.
- Includes a watchdog that recovers from a missing tx_done.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_HOLD, 2, cycles uart_en is held high per byte (≥2; the transmitter samples the edge through a 2-flop delay).
- GAP_CYC, 0, idle cycles inserted after each tx_done before the next byte starts.
- TIMEOUT_CYC, 8192, maximum cycles from uart_en rise to tx_done. Must exceed 10*CLK_FREQ/UART_BPS + 4; 4340 + 4 at 50 MHz / 115200.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  8*N_REQ  byte for requester i in bits [8i+7:8i]
- req_last  in  N_REQ  byte is the final byte of the requester's packet
- req_ready  out  N_REQ  one-hot one-cycle accept pulse
- uart_en  out  1  start request to the transmitter
- uart_din  out  8  byte to the transmitter
- tx_done  in  1  one-cycle end-of-frame pulse from the transmitter
- grant_id  out  $clog2(N_REQ)  current or last granted requester
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset is clk / rst_n, asynchronous, active-low. Reset values:
  - state IDLE
  - req_ready 0, uart_en 0, uart_din 0, grant_id 0, busy 0, timeout_err 0
  - round-robin pointer 0, lock 0
- Reset mid-frame drops everything. The in-flight byte is not retried.
- State machine: IDLE -> START -> WAIT -> GAP -> IDLE.
- IDLE, not locked:
  - If any req_valid, pick the first valid requester searching from the pointer upward with wrap-around (pointer = 0 gives priority 0,1,2,3).
  - In the same cycle: req_ready[g] = 1, uart_din <= req_data[g], grant_id <= g, lock <= ~req_last[g], last_r <= req_last[g]; go to START.
- IDLE, locked: only requester grant_id is eligible. Others wait even if valid; there is no timeout on the locked requester.
- START: uart_en = 1 for exactly START_HOLD cycles, then uart_en = 0 and go to WAIT. uart_din stays stable from capture until leaving WAIT.
- WAIT: watchdog counter runs from uart_en rise.
  - On tx_done: go to GAP. If GAP_CYC = 0, go straight to IDLE.
  - On counter reaching TIMEOUT_CYC - 1 with no tx_done: set timeout_err, clear lock, advance pointer to grant_id + 1 mod N_REQ, go to IDLE.
- GAP: count GAP_CYC cycles, then IDLE.
- Packet end: on leaving WAIT/GAP after a byte with last_r = 1, set lock = 0 and pointer <= grant_id + 1 mod N_REQ. The pointer does not move between bytes of a locked packet.
- Minimum byte-to-byte spacing: 1 (IDLE) + START_HOLD cycles before the frame, then tx_done, then GAP_CYC.
- uart_en low time between bytes is at least the full frame time, so the transmitter always sees a fresh rising edge.
- tx_done outside WAIT is ignored and does not change state.
- A requester dropping req_valid mid-packet while locked stalls the scheduler in IDLE.
- Counters: a watchdog counter of $clog2(TIMEOUT_CYC+1) bits, and a hold/gap counter sized for max(START_HOLD, GAP_CYC). Both clear on every state entry.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, WAIT, GAP)
  - UART_BYTE_W = 8
  - default TIMEOUT_CYC
- One sub-module: rr_arbiter. Inputs: request vector, pointer, lock, locked id. Outputs: combinational one-hot grant and its index. Parameterized by N_REQ.
- The FSM, counters and output registers stay in uart_tx_sched.

Test Plan:
- Single byte: req_valid[2] = 1, data 0xA5, last = 1, using a transmitter model with tx_done 4340 cycles after the edge.
  - req_ready[2] pulses once; uart_en high 2 cycles; uart_din = 0xA5 until tx_done; busy falls the cycle after tx_done; pointer becomes 3.
- Round-robin: all four valid with single-byte packets (0x10, 0x11, 0x12, 0x13), all last = 1.
  - Service order 0,1,2,3 with grant_id following.
  - Re-raising req 0 and 3 together next grants 0 (pointer wrapped to 0).
- Packet lock: req 1 sends a 3-byte packet (0x01, 0x02, 0x03 with last on 0x03) while req 0 and 2 are valid throughout.
  - All three bytes of req 1 go back-to-back; req 2 is granted next, then req 0.
- Timeout: model never pulses tx_done, TIMEOUT_CYC = 100.
  - timeout_err set 100 cycles after uart_en rise and stays set.
  - The next valid requester is served normally; a tx_done arriving later in IDLE is ignored.
- GAP_CYC = 5: two single-byte packets from req 0.
  - uart_en for the second byte rises exactly 7 cycles after the first tx_done (5 gap + 1 IDLE + 1).
- Reset mid-WAIT: assert rst_n low for 3 cycles.
  - All outputs return to reset values; a late tx_done after release is ignored; the pointer restarts at 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, byte width and default watchdog limit for the UART transmit scheduler
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int TIMEOUT_DEF = 8192;
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  function automatic int next_id(input int id, input int n);
    return (id + 1) % n;
  endfunction
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester byte handshake plus transmitter start/done link
// Ports (signals): req_valid/req_data/req_last/req_ready per requester; uart_en/uart_din/tx_done to the transmitter.
// Modports: master = requesters and transmitter side, slave = scheduler side.
interface uart_tx_sched_if #(parameter int N_REQ = 4);
  import uart_pkg::*;
  logic [N_REQ-1:0] req_valid, req_last, req_ready;
  logic [UART_BYTE_W*N_REQ-1:0] req_data;
  logic uart_en, tx_done;
  logic [UART_BYTE_W-1:0] uart_din;
  modport master (output req_valid, req_data, req_last, tx_done, input req_ready, uart_en, uart_din);
  modport slave (input req_valid, req_data, req_last, tx_done, output req_ready, uart_en, uart_din);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick from ptr upward with wrap; a lock restricts the pick to lock_id
// Ports: req request vector, ptr search start, lock/lock_id packet lock, gnt one-hot grant, gnt_id its index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             lock,
  input  logic [IW-1:0]    lock_id,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id
);
  logic [IW-1:0] k;
  // Scanning from the farthest offset down lets the nearest valid requester overwrite the result last.
  always_comb begin
    gnt = '0;
    gnt_id = lock_id;
    k = '0;
    if (lock) gnt[lock_id] = req[lock_id];
    else for (int i = N_REQ - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N_REQ);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        gnt_id = k;
      end
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one 8N1 transmitter among N_REQ byte streams with packet-level round-robin and a tx_done watchdog
// Ports: clk, rst_n (async active-low); bus (slave modport: requester handshake, uart_en/uart_din/tx_done);
//        grant_id current/last granted requester, busy high outside IDLE, timeout_err sticky watchdog flag.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int START_HOLD = 2,
  parameter int GAP_CYC = 0,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  localparam int IW = $clog2(N_REQ),
  localparam int WW = $clog2(TIMEOUT_CYC + 1),
  localparam int CW = $clog2((START_HOLD > GAP_CYC ? START_HOLD : GAP_CYC) + 1)
) (
  input  logic clk,
  input  logic rst_n,
  uart_tx_sched_if.slave bus,
  output logic [IW-1:0] grant_id,
  output logic busy,
  output logic timeout_err
);
  state_t state;
  logic lock, last_r;
  logic [IW-1:0] ptr, gnt_id, nxt_id;
  logic [N_REQ-1:0] gnt;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wdog;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(bus.req_valid), .ptr(ptr), .lock(lock), .lock_id(grant_id), .gnt(gnt), .gnt_id(gnt_id)
  );
  assign nxt_id = IW'(next_id(int'(grant_id), N_REQ));
  // Accept is combinational so the requester sees it in the cycle its byte is captured.
  assign bus.req_ready = (rst_n && state == IDLE) ? gnt : '0;
  // The watchdog starts at the uart_en rise and keeps counting through START into WAIT.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.uart_en <= 1'b0;
      bus.uart_din <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      ptr <= '0;
      lock <= 1'b0;
      last_r <= 1'b0;
      cnt <= '0;
      wdog <= '0;
    end else case (state)
      IDLE: if (|gnt) begin
        bus.uart_din <= bus.req_data[{gnt_id, 3'b000} +: UART_BYTE_W];
        grant_id <= gnt_id;
        lock <= ~bus.req_last[gnt_id];
        last_r <= bus.req_last[gnt_id];
        bus.uart_en <= 1'b1;
        busy <= 1'b1;
        cnt <= '0;
        wdog <= '0;
        state <= START;
      end
      START: begin
        wdog <= wdog + 1'b1;
        cnt <= (cnt == CW'(START_HOLD - 1)) ? '0 : cnt + 1'b1;
        if (cnt == CW'(START_HOLD - 1)) begin
          bus.uart_en <= 1'b0;
          state <= WAIT;
        end
      end
      WAIT: if (bus.tx_done) begin
        cnt <= '0;
        wdog <= '0;
        state <= (GAP_CYC == 0) ? IDLE : GAP;
        busy <= (GAP_CYC != 0);
        if (GAP_CYC == 0 && last_r) begin
          lock <= 1'b0;
          ptr <= nxt_id;
        end
      end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
        timeout_err <= 1'b1;
        lock <= 1'b0;
        ptr <= nxt_id;
        wdog <= '0;
        busy <= 1'b0;
        state <= IDLE;
      end else wdog <= wdog + 1'b1;
      GAP: if (cnt == CW'(GAP_CYC - 1)) begin
        cnt <= '0;
        busy <= 1'b0;
        state <= IDLE;
        if (last_r) begin
          lock <= 1'b0;
          ptr <= nxt_id;
        end
      end else cnt <= cnt + 1'b1;
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for two scheduler instances (default timing, and GAP_CYC=5 / TIMEOUT_CYC=100)
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic [1:0] rst_n = 2'b11;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(4)) ia ();
  uart_tx_sched_if #(.N_REQ(4)) ib ();
  logic [1:0] gid [2];
  logic [1:0] bz, te, en, dn, pe, mdl, inj;
  logic [7:0] din [2];
  logic [3:0] rdy [2], v [2], lst [2], rs [2];
  logic [31:0] dat [2];

  uart_tx_sched #(.N_REQ(4)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .bus(ia.slave), .grant_id(gid[0]), .busy(bz[0]), .timeout_err(te[0])
  );
  uart_tx_sched #(.N_REQ(4), .GAP_CYC(5), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .bus(ib.slave), .grant_id(gid[1]), .busy(bz[1]), .timeout_err(te[1])
  );

  assign ia.req_valid = v[0];
  assign ia.req_data = dat[0];
  assign ia.req_last = lst[0];
  assign ib.req_valid = v[1];
  assign ib.req_data = dat[1];
  assign ib.req_last = lst[1];
  assign ia.tx_done = mdl[0] | inj[0];
  assign ib.tx_done = mdl[1] | inj[1];
  assign en = {ib.uart_en, ia.uart_en};
  assign dn = {ib.tx_done, ia.tx_done};
  assign din[0] = ia.uart_din;
  assign din[1] = ib.uart_din;
  assign rdy[0] = ia.req_ready;
  assign rdy[1] = ib.req_ready;

  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: tx_done pulses lat cycles after the uart_en rise unless disabled.
  int lat [2] = '{20, 20};
  bit tx_on [2] = '{1'b1, 1'b1};
  int cd [2] = '{0, 0};
  initial begin
    pe = '0;
    mdl = '0;
    inj = '0;
  end
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      mdl[d] <= (cd[d] == 1) && tx_on[d];
      cd[d] <= (en[d] && !pe[d]) ? lat[d] : (cd[d] > 0 ? cd[d] - 1 : 0);
      pe[d] <= en[d];
    end

  // Requester model: per-requester byte queues, popped after an accepted cycle.
  logic [8:0] pq [2][4][$];
  logic [9:0] sb [2][$];
  logic [8:0] hd;
  initial begin
    v = '{4'h0, 4'h0};
    lst = '{4'h0, 4'h0};
    dat = '{32'h0, 32'h0};
  end
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        if (rs[d][i] && pq[d][i].size() > 0) void'(pq[d][i].pop_front());
        hd = (pq[d][i].size() > 0) ? pq[d][i][0] : 9'h0;
        v[d][i] = pq[d][i].size() > 0;
        lst[d][i] = hd[8];
        dat[d][8*i +: 8] = hd[7:0];
      end
  end

  // Monitor: scoreboard pop on each uart_en rise, pulse width, din stability and busy after tx_done.
  int cyc = 0;
  int run [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int gap [2] = '{0, 0};
  int rise_cyc [2] = '{0, 0};
  int te_cyc [2] = '{0, 0};
  int nrdy [2][4];
  logic [1:0] pen = '0, pdone = '0, pte = '0;
  logic [7:0] cur [2] = '{8'h0, 8'h0};
  logic [9:0] me;
  initial for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) nrdy[d][i] = 0;
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      rs[d] = rdy[d];
      if (|rdy[d]) check("ready_onehot", 32'($onehot(rdy[d])), 32'd1);
      for (int i = 0; i < 4; i++) if (rdy[d][i]) nrdy[d][i]++;
      if (pdone[d]) check("busy_after_done", 32'(bz[d]), 32'(d == 1));
      pdone[d] = dn[d] && bz[d];
      if (pdone[d]) begin
        check("din_held_to_done", 32'(din[d]), 32'(cur[d]));
        done_cyc[d] = cyc;
      end
      if (en[d] && !pen[d]) begin
        check("frame_expected", 32'(sb[d].size() > 0), 32'd1);
        if (sb[d].size() > 0) begin
          me = sb[d].pop_front();
          check("grant_id", 32'(gid[d]), 32'(me[9:8]));
          check("uart_din", 32'(din[d]), 32'(me[7:0]));
          cur[d] = me[7:0];
        end
        gap[d] = cyc - done_cyc[d];
        rise_cyc[d] = cyc;
      end
      if (!en[d] && pen[d]) check("uart_en_width", 32'(run[d]), 32'd2);
      run[d] = en[d] ? run[d] + 1 : 0;
      pen[d] = en[d];
      if (te[d] && !pte[d]) te_cyc[d] = cyc;
      pte[d] = te[d];
    end
  end

  task automatic send(input int d, input int i, input logic [7:0] b, input logic l);
    pq[d][i].push_back({l, b});
  endtask
  task automatic expect_byte(input int d, input int i, input logic [7:0] b);
    sb[d].push_back({2'(i), b});
  endtask
  function automatic bit pq_empty(input int d);
    bit e = 1'b1;
    for (int i = 0; i < 4; i++) if (pq[d][i].size() > 0) e = 1'b0;
    return e;
  endfunction
  task automatic wait_idle(input int d, input int bound);
    int n = 0;
    while (n < bound && !(bz[d] == 1'b0 && sb[d].size() == 0 && pq_empty(d))) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_reached", 32'(n < bound), 32'd1);
  endtask
  task automatic wait_sig(input string tag, input int d, input bit use_te, input int bound);
    int n = 0;
    while (n < bound && !(use_te ? te[d] : en[d])) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(n < bound), 32'd1);
  endtask
  task automatic check_rst(input int d);
    check("rst_uart_en", 32'(en[d]), 32'd0);
    check("rst_uart_din", 32'(din[d]), 32'd0);
    check("rst_grant_id", 32'(gid[d]), 32'd0);
    check("rst_busy", 32'(bz[d]), 32'd0);
    check("rst_timeout_err", 32'(te[d]), 32'd0);
    check("rst_req_ready", 32'(rdy[d]), 32'd0);
  endtask

  initial begin
    #2 rst_n = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check_rst(0);
    check_rst(1);
    rst_n = 2'b11;
    @(negedge clk);
    // Single byte with a full-length frame; pointer then sits at 3.
    lat[0] = 4340;
    send(0, 2, 8'hA5, 1'b1);
    expect_byte(0, 2, 8'hA5);
    wait_idle(0, 6000);
    check("single_ready_pulses", 32'(nrdy[0][2]), 32'd1);
    lat[0] = 20;
    send(0, 0, 8'h30, 1'b1);
    send(0, 3, 8'h33, 1'b1);
    expect_byte(0, 3, 8'h33);
    expect_byte(0, 0, 8'h30);
    wait_idle(0, 500);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    // Round robin from pointer 0, then wrap.
    for (int i = 0; i < 4; i++) begin
      send(0, i, 8'h10 + 8'(i), 1'b1);
      expect_byte(0, i, 8'h10 + 8'(i));
    end
    wait_idle(0, 1000);
    send(0, 0, 8'h20, 1'b1);
    send(0, 3, 8'h23, 1'b1);
    expect_byte(0, 0, 8'h20);
    expect_byte(0, 3, 8'h23);
    wait_idle(0, 500);
    send(0, 0, 8'h24, 1'b1);
    expect_byte(0, 0, 8'h24);
    wait_idle(0, 500);
    // Packet lock: pointer 1, requester 1 keeps the grant for its whole packet.
    send(0, 1, 8'h01, 1'b0);
    send(0, 1, 8'h02, 1'b0);
    send(0, 1, 8'h03, 1'b1);
    send(0, 0, 8'h40, 1'b1);
    send(0, 2, 8'h42, 1'b1);
    expect_byte(0, 1, 8'h01);
    expect_byte(0, 1, 8'h02);
    expect_byte(0, 1, 8'h03);
    expect_byte(0, 2, 8'h42);
    expect_byte(0, 0, 8'h40);
    wait_idle(0, 1000);
    // Reset mid-WAIT; the model's late tx_done must be ignored and the pointer restarts at 0.
    send(0, 2, 8'h77, 1'b1);
    expect_byte(0, 2, 8'h77);
    wait_sig("rise_before_reset", 0, 1'b0, 100);
    repeat (4) @(negedge clk);
    #1;
    rst_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_rst(0);
    rst_n[0] = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("late_done_busy", 32'(bz[0]), 32'd0);
    check("late_done_uart_en", 32'(en[0]), 32'd0);
    send(0, 1, 8'h51, 1'b1);
    send(0, 0, 8'h50, 1'b1);
    expect_byte(0, 0, 8'h50);
    expect_byte(0, 1, 8'h51);
    wait_idle(0, 500);
    // Watchdog on the short-timeout instance.
    tx_on[1] = 1'b0;
    send(1, 1, 8'h61, 1'b1);
    expect_byte(1, 1, 8'h61);
    wait_sig("timeout_rise_seen", 1, 1'b0, 100);
    wait_sig("timeout_err_seen", 1, 1'b1, 300);
    check("timeout_latency", 32'(te_cyc[1] - rise_cyc[1]), 32'd100);
    repeat (50) @(negedge clk);
    #1;
    check("timeout_sticky", 32'(te[1]), 32'd1);
    tx_on[1] = 1'b1;
    send(1, 2, 8'h62, 1'b1);
    expect_byte(1, 2, 8'h62);
    wait_idle(1, 500);
    inj[1] = 1'b1;
    @(negedge clk);
    inj[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("stray_done_busy", 32'(bz[1]), 32'd0);
    check("stray_done_uart_en", 32'(en[1]), 32'd0);
    check("timeout_still_set", 32'(te[1]), 32'd1);
    // Inter-byte gap of 5 cycles.
    send(1, 0, 8'hC0, 1'b1);
    send(1, 0, 8'hC1, 1'b1);
    expect_byte(1, 0, 8'hC0);
    expect_byte(1, 0, 8'hC1);
    wait_idle(1, 500);
    check("gap_spacing", 32'(gap[1]), 32'd7);
    check("sb_a_drained", 32'(sb[0].size()), 32'd0);
    check("sb_b_drained", 32'(sb[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
